histogram_compressor_nway: RTL and testbench

- Joint-histogram compressor for NUM_STREAMS parallel unary bitstreams.
- Counts occurrences of each of 2^NUM_STREAMS bit patterns over a frame of exactly STREAM_LENGTH accepted samples.
- At frame end, publishes the full histogram through a valid/ready output handshake.
- Sits between the unary stream generators and the downstream packer/decompressor. Generalises the fixed two-stream, free-running counter block with framing, handshakes and arbitrary stream count.

---
 rtl/histogram_compressor_nway_pkg.sv | 15 +
 rtl/histogram_compressor_nway_bin_counter.sv | 18 +
 rtl/histogram_compressor_nway.sv | 87 ++++++++
 tb/tb_histogram_compressor_nway.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/histogram_compressor_nway_pkg.sv
// Shared types and helpers for the n-way joint-histogram compressor.
package histogram_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} hist_state_e;

  function automatic int num_bins(input int n);
    return 1 << n;
  endfunction

  // Bit offset of bin k inside the flattened histogram bus.
  function automatic int bin_offset(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/histogram_compressor_nway_bin_counter.sv
// One histogram bin: counter with synchronous clear and increment enable.
module hist_bin_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/histogram_compressor_nway.sv
// Framed joint histogram of NUM_STREAMS unary bitstreams, published via valid/ready.
module histogram_compressor_nway
  import histogram_pkg::*;
#(
  parameter int NUM_STREAMS   = 2,
  parameter int STREAM_LENGTH = 128,
  parameter int COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1),
  parameter int NUM_BINS      = num_bins(NUM_STREAMS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [NUM_STREAMS-1:0]            stream_in,
  input  logic                              valid_in,
  output logic                              ready_in,
  output logic [NUM_BINS*COUNTER_WIDTH-1:0] hist_out,
  output logic                              hist_valid,
  input  logic                              hist_ready,
  output logic                              busy,
  output logic [COUNTER_WIDTH-1:0]          sample_count
);

  hist_state_e state, state_nxt;

  logic [NUM_BINS-1:0][COUNTER_WIDTH-1:0] bin_cnt, bin_nxt, hist_q;
  logic [NUM_BINS-1:0]                    bin_inc;
  logic                                   accept, frame_clr, frame_done;

  assign accept     = (state == ST_ACCUM) && valid_in;
  assign frame_clr  = (state == ST_IDLE) && start;
  assign frame_done = accept && (sample_count == COUNTER_WIDTH'(STREAM_LENGTH - 1));

  genvar k;
  generate
    for (k = 0; k < NUM_BINS; k++) begin : g_bin
      assign bin_inc[k] = accept && (stream_in == NUM_STREAMS'(k));
      hist_bin_counter #(.W(COUNTER_WIDTH)) u_bin (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_clr),
        .inc   (bin_inc[k]),
        .cnt   (bin_cnt[k])
      );
      // Snapshot must include the sample accepted on the closing cycle.
      assign bin_nxt[k] = bin_cnt[k] + COUNTER_WIDTH'(bin_inc[k]);
      assign hist_out[bin_offset(k, COUNTER_WIDTH) +: COUNTER_WIDTH] = hist_q[k];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)          hist_q <= '0;
    else if (frame_done) hist_q <= bin_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         sample_count <= '0;
    else if (frame_clr) sample_count <= '0;
    else if (accept)    sample_count <= sample_count + COUNTER_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready_in   = 1'b0;
    hist_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ACCUM;
      ST_ACCUM: begin
        ready_in = 1'b1;
        busy     = 1'b1;
        if (frame_done) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        hist_valid = 1'b1;
        busy       = 1'b1;
        if (hist_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_histogram_compressor_nway.sv
// Bench: per-cycle model check on a 2-stream/8-sample instance plus directed 3-stream and 1-stream frames.
module tb_histogram_compressor_nway;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_STREAMS=2, STREAM_LENGTH=8
  logic        start_a = 0, valid_a = 0, hready_a = 0;
  logic [1:0]  stream_a = 0;
  logic        ready_a, hvalid_a, busy_a;
  logic [15:0] hist_a;
  logic [3:0]  cnt_a;

  // Instance B: NUM_STREAMS=3, STREAM_LENGTH=16
  logic        start_b = 0, valid_b = 0, hready_b = 0;
  logic [2:0]  stream_b = 0;
  logic        ready_b, hvalid_b, busy_b;
  logic [39:0] hist_b;
  logic [4:0]  cnt_b;

  // Instance C: NUM_STREAMS=1, STREAM_LENGTH=1
  logic        start_c = 0, valid_c = 0, hready_c = 0;
  logic [0:0]  stream_c = 0;
  logic        ready_c, hvalid_c, busy_c;
  logic [1:0]  hist_c;
  logic [0:0]  cnt_c;

  histogram_compressor_nway #(.NUM_STREAMS(2), .STREAM_LENGTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stream_in(stream_a), .valid_in(valid_a),
    .ready_in(ready_a), .hist_out(hist_a), .hist_valid(hvalid_a), .hist_ready(hready_a),
    .busy(busy_a), .sample_count(cnt_a));

  histogram_compressor_nway #(.NUM_STREAMS(3), .STREAM_LENGTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stream_in(stream_b), .valid_in(valid_b),
    .ready_in(ready_b), .hist_out(hist_b), .hist_valid(hvalid_b), .hist_ready(hready_b),
    .busy(busy_b), .sample_count(cnt_b));

  histogram_compressor_nway #(.NUM_STREAMS(1), .STREAM_LENGTH(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .stream_in(stream_c), .valid_in(valid_c),
    .ready_in(ready_c), .hist_out(hist_c), .hist_valid(hvalid_c), .hist_ready(hready_c),
    .busy(busy_c), .sample_count(cnt_c));

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model of instance A: frame phase, per-pattern tallies, published snapshot.
  int m_phase = 0;            // 0 idle, 1 collecting, 2 holding result
  int m_bins[4] = '{0, 0, 0, 0};
  int m_hist[4] = '{0, 0, 0, 0};
  int m_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0;
      foreach (m_bins[i]) begin m_bins[i] = 0; m_hist[i] = 0; end
    end else begin
      case (m_phase)
        0: if (start_a) begin
             m_phase = 1; m_cnt = 0;
             foreach (m_bins[i]) m_bins[i] = 0;
           end
        1: if (valid_a) begin
             m_bins[int'(stream_a)]++;
             m_cnt++;
             if (m_cnt == 8) begin
               foreach (m_bins[i]) m_hist[i] = m_bins[i];
               m_phase = 2;
             end
           end
        default: if (hready_a) m_phase = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    logic [15:0] exp_h;
    #2;
    for (int i = 0; i < 4; i++) exp_h[i*4 +: 4] = 4'(m_hist[i]);
    chk("a_ready_in",   32'(ready_a),  32'(m_phase == 1));
    chk("a_busy",       32'(busy_a),   32'(m_phase != 0));
    chk("a_hist_valid", 32'(hvalid_a), 32'(m_phase == 2));
    chk("a_sample_cnt", 32'(cnt_a),    32'(m_cnt));
    chk("a_hist_out",   32'(hist_a),   32'(exp_h));
  end

  // Apply A inputs just after a rising edge, return after the next edge has settled.
  task automatic step(input logic s, input logic v, input logic [1:0] d, input logic hr);
    start_a = s; valid_a = v; stream_a = d; hready_a = hr;
    @(posedge clk); #2;
  endtask

  task automatic idle_b_c_cycle();
    @(posedge clk); #2;
  endtask

  initial begin
    logic [1:0] pat [8];
    pat = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10};

    // Reset and idle
    rst_n = 0;
    repeat (2) begin @(posedge clk); #2; end
    rst_n = 1;
    repeat (10) step(0, 0, 0, 0);
    chk("reset_hist_out", 32'(hist_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);

    // Basic frame
    step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, pat[i], 1);
    chk("basic_valid_latency", 32'(hvalid_a), 32'h1);
    chk("basic_bins", 32'(hist_a), 32'h3212);
    step(0, 0, 0, 1);
    chk("basic_valid_one_cycle", 32'(hvalid_a), 32'h0);
    chk("basic_hist_kept", 32'(hist_a), 32'h3212);

    // Backpressure and gaps
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 2'b11, 0);
      step(0, 1, pat[i], 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2'b11, 0);
      chk("bp_hold_valid", 32'(hvalid_a), 32'h1);
      chk("bp_hold_stable", 32'(hist_a), 32'h3212);
    end
    step(0, 0, 0, 1);
    chk("bp_release", 32'(hvalid_a), 32'h0);

    // Start ignored mid-frame and in hold (including handshake cycle)
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 0);
    step(1, 1, 2'b01, 0);
    chk("start_ignored_cnt", 32'(cnt_a), 32'h4);
    for (int i = 0; i < 4; i++) step(0, 1, 2'b01, 0);
    chk("start_frame_bins", 32'(hist_a), 32'h0080);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("start_handshake_idle", 32'(busy_a), 32'h0);
    step(0, 0, 0, 0);
    chk("start_still_idle", 32'(busy_a), 32'h0);

    // Reset mid-frame
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 2'b10, 0);
    rst_n = 0;
    step(0, 0, 0, 0);
    chk("rst_mid_cnt", 32'(cnt_a), 32'h0);
    chk("rst_mid_busy", 32'(busy_a), 32'h0);
    rst_n = 1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b11, 0);
    chk("rst_new_frame", 32'(hist_a), 32'h8000);
    step(0, 0, 0, 1);

    // Three streams, sixteen samples: every pattern twice
    start_b = 1; idle_b_c_cycle(); start_b = 0;
    for (int i = 0; i < 16; i++) begin
      valid_b = 1; stream_b = 3'(i);
      idle_b_c_cycle();
    end
    valid_b = 0;
    chk("n3_valid", 32'(hvalid_b), 32'h1);
    begin
      int sum = 0;
      for (int k = 0; k < 8; k++) begin
        chk("n3_bin", 32'(hist_b[k*5 +: 5]), 32'd2);
        sum += int'(hist_b[k*5 +: 5]);
      end
      chk("n3_sum", 32'(sum), 32'd16);
    end
    hready_b = 1; idle_b_c_cycle(); hready_b = 0;
    chk("n3_release", 32'(hvalid_b), 32'h0);

    // One stream, one-sample frame
    start_c = 1; idle_b_c_cycle(); start_c = 0;
    chk("n1_ready", 32'(ready_c), 32'h1);
    valid_c = 1; stream_c = 1'b1; idle_b_c_cycle(); valid_c = 0;
    chk("n1_valid", 32'(hvalid_c), 32'h1);
    chk("n1_bins", 32'(hist_c), 32'h2);
    chk("n1_cnt", 32'(cnt_c), 32'h1);
    hready_c = 1; idle_b_c_cycle(); hready_c = 0;
    chk("n1_release", 32'(hvalid_c), 32'h0);

    repeat (2) step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
